xoodyak_aead_core: RTL and testbench
====================================

// Module: xoodyak_aead_core
// PURPOSE
//  Single-block Xoodyak AEAD engine (keyed Cyclist, Xoodoo[12], 384-bit state).
//  Absorbs 128b key, 128b nonce, 128b AD; encrypts/decrypts one 192b block; squeezes 128b tag.
//  Sits between host registers and the verify logic; encrypt/decrypt instances chain via sqzdone.
// PARAMETERS
//  NROUNDS   12   Xoodoo rounds per permutation (one round per clock)
// PORTS
//  eph1              in   1    clock, all flops rising edge
//  reset             in   1    asynchronous, active-low (0 = reset asserted)
//  start             in   1    begin operation; sampled only in IDLE
//  textin            in   192  plaintext (opmode=0) or ciphertext (opmode=1)
//  nonce             in   128  nonce
//  assodata          in   128  associated data
//  key               in   128  secret key
//  verification_data in   128  expected tag (decrypt); ignored in encrypt
//  opmode            in   1    0 encrypt, 1 decrypt
//  authdata          out  128  computed tag
//  textout           out  192  ciphertext (enc) or recovered plaintext (dec)
//  encdone           out  1    1-cycle pulse: textout valid
//  sqzdone           out  1    1-cycle pulse: authdata/verify valid
//  verify            out  1    decrypt: authdata==verification_data; encrypt: 0
// BEHAVIOUR
//  Byte order little-endian: byte i = bits[8i+7:8i] of every bus and of state S[383:0].
//  Lane (x,y) = S[32*(4y+x)+31 -: 32]. Cu/Cd XOR into byte 47; pad 0x01 after data.
//  Inputs sampled once at start edge T into internal copies; later changes ignored.
//  Edge T: S <= {0, 0x02 @b47, 0x01 @b17, 0x00 @b16, key @b0..15} (AbsorbKey Down; Up Cu=0x00).
//  Phase A, rounds T+1..T+12: at last round S ^= nonce@b0..15, 0x01@b16, 0x03@b47 (Down).
//  Phase B, T+13..T+24: then S ^= assodata, 0x01@b16, 0x03@b47, then Cu 0x80@b47.
//  Phase C, T+25..T+36: O = S[191:0]^textin -> textout; enc: S[191:0]^=textin;
//    dec: S[191:0]=textin; S ^= 0x01@b24, 0x40@b47 (Down Cd=0, Up Cu=0x40).
//  Phase D, T+37..T+48: authdata <= S[127:0]; verify <= opmode & (S[127:0]==verification_data).
//  encdone high exactly the cycle after edge T+36; sqzdone the cycle after T+48.
//  Round: theta (P=A0^A1^A2; E=(P<<<(1,5))^(P<<<(1,14)) lane-shift x-1), rho-west
//    (A1 x-shift 1, A2 <<<11), iota (A0[0,0]^=RC), chi, rho-east (A1 <<<1, A2 x-shift 2, <<<8).
//  RC = 058,038,3C0,0D0,120,014,060,02C,380,0F0,1A0,012 (hex, round 0..11).
//  FSM: IDLE -> RUN(phase 0..3, round 0..11) -> IDLE; 4-bit round ctr wraps 11->0, phase++.
//  start while RUN: ignored. start and encdone same cycle: no interaction.
//  textout/authdata/verify hold until overwritten by next op (textout at its T+36).
//  Reset (any time, incl. mid-op): IDLE, S=0, all outputs 0, counters 0; start in same cycle
//    as reset release ignored.
//  Total latency start->sqzdone 49 cycles; back-to-back start accepted the cycle sqzdone high.
// STRUCTURE
//  Package xoodyak_pkg: state typedef (384b), lane/plane typedefs, RC table, Cd/Cu constants
//    (0x02 key, 0x03 absorb, 0x80 crypt, 0x40 squeeze), NROUNDS.
//  Sub-module xoodoo_round: combinational one round (state, rc) -> state.
//  Non-reset datapath regs from codebase rregs #(W)(q,d,eph1); control/output regs with async reset.
// TESTING
//  Enc: key 0x38393a3b..3637, nonce 0x494a4b4c..4748, AD 0x696a6b6c..6768,
//    pt 0x4d4e4f50..4b4c, opmode 0 -> encdone at T+37, sqzdone at T+49, verify 0; match C model.
//  Round-trip: 2nd instance opmode 1, start=1st sqzdone, textin=textout delayed 3 cyc,
//    verification_data=authdata -> textout=pt 0x4d4e..4b4c, verify=1, same tag.
//  Tamper: flip textin bit 0 or verification_data bit 127 on decrypt -> verify=0.
//  Reset pulse (reset=0) at T+20 -> no encdone/sqzdone, outputs 0; restart gives same tag.
//  start pulsed at T+5 and T+30 -> ignored; single sqzdone at T+49, results unchanged.
//  Permutation unit: xoodoo_round x12 on all-zero state equals reference Xoodoo[12] C model.

Source files
------------

// File: rtl/xoodyak_pkg.sv
// xoodyak_pkg: shared types, domain constants and round constants for the Xoodyak AEAD core
package xoodyak_pkg;
  localparam int NROUNDS = 12;
  localparam int MAX_ROUNDS = 12;
  typedef logic [31:0] lane_t;
  typedef lane_t [3:0] plane_t;
  typedef plane_t [2:0] state_t;
  typedef enum logic [1:0] {PH_NONCE, PH_AD, PH_CRYPT, PH_SQZ} phase_t;
  localparam logic [7:0] CD_KEY = 8'h02;
  localparam logic [7:0] CD_ABSORB = 8'h03;
  localparam logic [7:0] CU_CRYPT = 8'h80;
  localparam logic [7:0] CU_SQUEEZE = 8'h40;
  // Padded to 16 entries so a 4-bit round index can never run off the table
  localparam lane_t RC_TAB [16] = '{
    32'h058, 32'h038, 32'h3c0, 32'h0d0, 32'h120, 32'h014,
    32'h060, 32'h02c, 32'h380, 32'h0f0, 32'h1a0, 32'h012,
    32'h0, 32'h0, 32'h0, 32'h0
  };
  function automatic lane_t rotl(input lane_t v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  function automatic logic [383:0] byte_at(input int i, input logic [7:0] v);
    return 384'(v) << (8 * i);
  endfunction
endpackage

// File: rtl/xoodyak_aead_core_if.sv
// xoodyak_aead_core_if: host-side operand/result bundle of the AEAD core
interface xoodyak_aead_core_if;
  logic start;
  logic [191:0] textin;
  logic [127:0] nonce;
  logic [127:0] assodata;
  logic [127:0] key;
  logic [127:0] verification_data;
  logic opmode;
  logic [127:0] authdata;
  logic [191:0] textout;
  logic encdone;
  logic sqzdone;
  logic verify;
  modport master (
    output start, textin, nonce, assodata, key, verification_data, opmode,
    input authdata, textout, encdone, sqzdone, verify
  );
  modport slave (
    input start, textin, nonce, assodata, key, verification_data, opmode,
    output authdata, textout, encdone, sqzdone, verify
  );
endinterface

// File: rtl/rregs.sv
// rregs: plain non-reset register bank for datapath operands
module rregs #(
  parameter int W = 1
) (
  output logic [W-1:0] q,
  input logic [W-1:0] d,
  input logic eph1
);
  always_ff @(posedge eph1) q <= d;
endmodule

// File: rtl/xoodoo_round.sv
// xoodoo_round: one combinational Xoodoo round (theta, rho-west, iota, chi, rho-east)
module xoodoo_round
  import xoodyak_pkg::*;
(
  input state_t s_i,
  input lane_t rc_i,
  output state_t s_o
);
  plane_t p, e;
  state_t t, w;
  always_comb begin
    p = s_i[0] ^ s_i[1] ^ s_i[2];
    e = '0;
    t = '0;
    w = '0;
    s_o = '0;
    for (int x = 0; x < 4; x++) e[x] = rotl(p[2'(x + 3)], 5) ^ rotl(p[2'(x + 3)], 14);
    for (int x = 0; x < 4; x++) begin
      t[0][x] = s_i[0][x] ^ e[x];
      t[1][x] = s_i[1][x] ^ e[x];
      t[2][x] = s_i[2][x] ^ e[x];
    end
    for (int x = 0; x < 4; x++) begin
      w[0][x] = t[0][x] ^ (x == 0 ? rc_i : '0);
      w[1][x] = t[1][2'(x + 3)];
      w[2][x] = rotl(t[2][x], 11);
    end
    // chi folded with rho-east: plane 2 reads its chi inputs at the pre-shift column
    for (int x = 0; x < 4; x++) begin
      s_o[0][x] = w[0][x] ^ (~w[1][x] & w[2][x]);
      s_o[1][x] = rotl(w[1][x] ^ (~w[2][x] & w[0][x]), 1);
      s_o[2][x] = rotl(w[2][2'(x + 2)] ^ (~w[0][2'(x + 2)] & w[1][2'(x + 2)]), 8);
    end
  end
endmodule

// File: rtl/xoodyak_aead_core.sv
// xoodyak_aead_core: single-block keyed Xoodyak AEAD, one Xoodoo round per clock,
// four 12-round phases (nonce, AD, crypt, squeeze) after the key is loaded at start.
module xoodyak_aead_core
  import xoodyak_pkg::*;
#(
  parameter int NROUNDS = xoodyak_pkg::NROUNDS
) (
  input logic eph1,
  input logic reset,
  xoodyak_aead_core_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam logic [3:0] RND_LAST = 4'(NROUNDS - 1);
  localparam logic [3:0] RC_OFS = 4'(MAX_ROUNDS - NROUNDS);
  logic [0:0] st_q, st_d;
  phase_t phase_q, phase_d;
  logic [3:0] rnd_q, rnd_d;
  logic ready_q, go, run, last, op_q;
  logic encdone_q, encdone_d, sqzdone_q, sqzdone_d, verify_q, verify_d;
  logic [383:0] s_q, s_d, r, key_init, absorb, crypt;
  logic [191:0] text_q, out_blk, textout_q, textout_d;
  logic [127:0] nonce_q, ad_q, vdata_q, authdata_q, authdata_d;
  // ready_q blocks a start that coincides with reset release
  assign go = st_q == ST_IDLE && ready_q && bus.start;
  assign run = st_q == ST_RUN;
  assign last = run && rnd_q == RND_LAST;
  rregs #(.W(128)) u_nonce (.q(nonce_q), .d(go ? bus.nonce : nonce_q), .eph1(eph1));
  rregs #(.W(128)) u_ad (.q(ad_q), .d(go ? bus.assodata : ad_q), .eph1(eph1));
  rregs #(.W(128)) u_vdata (.q(vdata_q), .d(go ? bus.verification_data : vdata_q), .eph1(eph1));
  rregs #(.W(192)) u_text (.q(text_q), .d(go ? bus.textin : text_q), .eph1(eph1));
  rregs #(.W(1)) u_op (.q(op_q), .d(go ? bus.opmode : op_q), .eph1(eph1));
  xoodoo_round u_round (.s_i(s_q), .rc_i(RC_TAB[RC_OFS + rnd_q]), .s_o(r));
  assign key_init = {256'b0, bus.key} ^ byte_at(17, 8'h01) ^ byte_at(47, CD_KEY);
  assign absorb = r ^ {256'b0, phase_q == PH_NONCE ? nonce_q : ad_q} ^ byte_at(16, 8'h01)
                ^ byte_at(47, phase_q == PH_NONCE ? CD_ABSORB : CD_ABSORB ^ CU_CRYPT);
  // Both directions leave the ciphertext in the rate: enc writes r^pt, dec copies ct
  assign out_blk = r[191:0] ^ text_q;
  assign crypt = {r[383:192], op_q ? text_q : out_blk} ^ byte_at(24, 8'h01) ^ byte_at(47, CU_SQUEEZE);
  assign s_d = go ? key_init : !last ? (run ? r : s_q)
             : phase_q == PH_CRYPT ? crypt : phase_q == PH_SQZ ? r : absorb;
  assign rnd_d = run && !last ? rnd_q + 4'd1 : '0;
  assign phase_d = last ? phase_t'(phase_q + 2'd1) : run ? phase_q : PH_NONCE;
  assign st_d = go ? ST_RUN : last && phase_q == PH_SQZ ? ST_IDLE : st_q;
  assign encdone_d = last && phase_q == PH_CRYPT;
  assign sqzdone_d = last && phase_q == PH_SQZ;
  assign textout_d = encdone_d ? out_blk : textout_q;
  assign authdata_d = sqzdone_d ? r[127:0] : authdata_q;
  assign verify_d = sqzdone_d ? op_q && r[127:0] == vdata_q : verify_q;
  always_ff @(posedge eph1 or negedge reset)
    if (!reset) begin
      st_q <= ST_IDLE;
      phase_q <= PH_NONCE;
      rnd_q <= '0;
      ready_q <= 1'b0;
      s_q <= '0;
      textout_q <= '0;
      authdata_q <= '0;
      verify_q <= 1'b0;
      encdone_q <= 1'b0;
      sqzdone_q <= 1'b0;
    end else begin
      st_q <= st_d;
      phase_q <= phase_d;
      rnd_q <= rnd_d;
      ready_q <= 1'b1;
      s_q <= s_d;
      textout_q <= textout_d;
      authdata_q <= authdata_d;
      verify_q <= verify_d;
      encdone_q <= encdone_d;
      sqzdone_q <= sqzdone_d;
    end
  assign bus.textout = textout_q;
  assign bus.authdata = authdata_q;
  assign bus.verify = verify_q;
  assign bus.encdone = encdone_q;
  assign bus.sqzdone = sqzdone_q;
endmodule

// File: tb/tb_xoodyak_aead_core.sv
// tb_xoodyak_aead_core: scoreboard bench against a Cyclist-style Xoodyak model
module tb_xoodyak_aead_core;
  localparam logic [127:0] KEY = 128'h38393a3b3c3d3e3f3031323334353637;
  localparam logic [127:0] NONCE = 128'h494a4b4c4d4e4f504142434445464748;
  localparam logic [127:0] AD = 128'h696a6b6c6d6e6f706162636465666768;
  localparam logic [191:0] PT = 192'h4d4e4f505152535455565758_4142434445464748494a4b4c;
  localparam logic [31:0] RC_TB [12] = '{
    32'h058, 32'h038, 32'h3c0, 32'h0d0, 32'h120, 32'h014,
    32'h060, 32'h02c, 32'h380, 32'h0f0, 32'h1a0, 32'h012
  };
  typedef struct { int at; logic [191:0] txt; } enc_exp_t;
  typedef struct { int at; logic [127:0] tag; logic ver; } sqz_exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  enc_exp_t enc_q[$];
  sqz_exp_t sqz_q[$];
  enc_exp_t ee;
  sqz_exp_t se;
  logic [383:0] pc [13];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  xoodyak_aead_core_if bus();
  xoodyak_aead_core dut (.eph1(clk), .reset(reset), .bus(bus));
  assign pc[0] = '0;
  for (genvar i = 0; i < 12; i++) begin : g_perm
    xoodoo_round u_r (.s_i(pc[i]), .rc_i(RC_TB[i]), .s_o(pc[i+1]));
  end
  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  function automatic logic [383:0] xperm(input logic [383:0] s);
    logic [31:0] a [3][4];
    logic [31:0] b [3][4];
    logic [31:0] p [4];
    for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) a[y][x] = s[32*(4*y+x) +: 32];
    for (int r = 0; r < 12; r++) begin
      for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] ^= rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
      b = a;
      for (int x = 0; x < 4; x++) begin
        b[1][x] = a[1][(x+3)%4];
        b[2][x] = rol(a[2][x], 11);
      end
      b[0][0] ^= RC_TB[r];
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
      b = a;
      for (int x = 0; x < 4; x++) begin
        b[1][x] = rol(a[1][x], 1);
        b[2][x] = rol(a[2][(x+2)%4], 8);
      end
      a = b;
    end
    for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) s[32*(4*y+x) +: 32] = a[y][x];
    return s;
  endfunction
  // Cyclist sequence: AbsorbKey, Absorb(nonce), Absorb(AD), Crypt, Squeeze
  function automatic void model(input logic [127:0] k, n, a, input logic [191:0] tin,
                                input logic dec, input logic [127:0] vd,
                                output logic [191:0] tout, output logic [127:0] tag, output logic ver);
    logic [383:0] s = '0;
    logic [191:0] pt;
    s[127:0] = k;
    s[8*17 +: 8] = 8'h01;
    s[8*47 +: 8] = 8'h02;
    s = xperm(s);
    s[127:0] ^= n;
    s[8*16 +: 8] ^= 8'h01;
    s[8*47 +: 8] ^= 8'h03;
    s = xperm(s);
    s[127:0] ^= a;
    s[8*16 +: 8] ^= 8'h01;
    s[8*47 +: 8] ^= 8'h03;
    s[8*47 +: 8] ^= 8'h80;
    s = xperm(s);
    tout = s[191:0] ^ tin;
    pt = dec ? tout : tin;
    s[191:0] ^= pt;
    s[8*24 +: 8] ^= 8'h01;
    s[8*47 +: 8] ^= 8'h40;
    s = xperm(s);
    tag = s[127:0];
    ver = dec && tag == vd;
  endfunction
  // Call at a negedge; returns at the negedge following the accepting edge T with t = cycle of T
  task automatic run_op(input logic [127:0] k, n, a, input logic [191:0] txt, input logic dec,
                        input logic [127:0] vd, output int t);
    logic [191:0] eo;
    logic [127:0] tg;
    logic v;
    model(k, n, a, txt, dec, vd, eo, tg, v);
    bus.key = k;
    bus.nonce = n;
    bus.assodata = a;
    bus.textin = txt;
    bus.opmode = dec;
    bus.verification_data = vd;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t = cyc;
    enc_q.push_back('{t + 36, eo});
    sqz_q.push_back('{t + 48, tg, v});
  endtask
  task automatic drain(input int budget);
    for (int n = 0; n < budget && (enc_q.size() != 0 || sqz_q.size() != 0); n++) @(negedge clk);
    check("drain_timeout", 384'(enc_q.size() + sqz_q.size()), '0);
  endtask
  task automatic wait_sqz(input int budget);
    for (int n = 0; n < budget && !bus.sqzdone; n++) @(negedge clk);
    check("sqz_timeout", bus.sqzdone, 1'b1);
  endtask
  always @(negedge clk) begin
    if (reset && bus.encdone) begin
      if (enc_q.size() == 0) check("enc_spurious", bus.encdone, 1'b0);
      else begin
        ee = enc_q.pop_front();
        check("enc_cycle", cyc, ee.at);
        check("textout", bus.textout, ee.txt);
      end
    end
    if (reset && bus.sqzdone) begin
      if (sqz_q.size() == 0) check("sqz_spurious", bus.sqzdone, 1'b0);
      else begin
        se = sqz_q.pop_front();
        check("sqz_cycle", cyc, se.at);
        check("authdata", bus.authdata, se.tag);
        check("verify", bus.verify, se.ver);
      end
    end
  end
  initial begin
    int t;
    logic [191:0] ct0, rc_ct;
    logic [127:0] tag0, rk, rn, ra, rc_tag;
    logic [191:0] rp;
    logic v0;
    bus.start = 1'b0;
    bus.textin = '0;
    bus.nonce = '0;
    bus.assodata = '0;
    bus.key = '0;
    bus.verification_data = '0;
    bus.opmode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_textout", bus.textout, '0);
    check("rst_authdata", bus.authdata, '0);
    check("rst_verify", bus.verify, 1'b0);
    check("rst_encdone", bus.encdone, 1'b0);
    check("rst_sqzdone", bus.sqzdone, 1'b0);
    check("perm12_zero", pc[12], xperm('0));
    bus.key = KEY;
    bus.start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (55) @(negedge clk);
    check("rel_start_ignored", bus.authdata, '0);
    model(KEY, NONCE, AD, PT, 1'b0, '0, ct0, tag0, v0);
    run_op(KEY, NONCE, AD, PT, 1'b0, '0, t);
    wait_sqz(100);
    run_op(KEY, NONCE, AD, ct0, 1'b1, tag0, t);
    drain(100);
    check("rt_textout", bus.textout, PT);
    check("rt_tag", bus.authdata, tag0);
    check("rt_verify", bus.verify, 1'b1);
    run_op(KEY, NONCE, AD, ct0 ^ 192'd1, 1'b1, tag0, t);
    drain(100);
    check("tamper_ct_verify", bus.verify, 1'b0);
    run_op(KEY, NONCE, AD, ct0, 1'b1, tag0 ^ {1'b1, 127'b0}, t);
    drain(100);
    check("tamper_tag_verify", bus.verify, 1'b0);
    run_op(KEY, NONCE, AD, PT, 1'b0, '0, t);
    while (cyc < t + 5) @(negedge clk);
    bus.start = 1'b1;
    bus.key = {$urandom, $urandom, $urandom, $urandom};
    bus.textin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.nonce = ~NONCE;
    bus.opmode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t + 30) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain(100);
    check("ign_textout", bus.textout, ct0);
    check("ign_tag", bus.authdata, tag0);
    run_op(KEY, NONCE, AD, PT, 1'b0, '0, t);
    while (cyc < t + 20) @(negedge clk);
    reset = 1'b0;
    enc_q.delete();
    sqz_q.delete();
    @(negedge clk);
    check("rst_mid_textout", bus.textout, '0);
    check("rst_mid_authdata", bus.authdata, '0);
    check("rst_mid_verify", bus.verify, 1'b0);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_mid_quiet", bus.textout, '0);
    run_op(KEY, NONCE, AD, PT, 1'b0, '0, t);
    drain(100);
    check("restart_tag", bus.authdata, tag0);
    for (int i = 0; i < 3; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rn = {$urandom, $urandom, $urandom, $urandom};
      ra = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model(rk, rn, ra, rp, 1'b0, '0, rc_ct, rc_tag, v0);
      run_op(rk, rn, ra, rp, 1'b0, '0, t);
      drain(100);
      run_op(rk, rn, ra, rc_ct, 1'b1, rc_tag, t);
      drain(100);
      check("rand_rt_textout", bus.textout, rp);
    end
    check("left_enc", 384'(enc_q.size()), '0);
    check("left_sqz", 384'(sqz_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
